i2s_rx: RTL

- Slave-mode I2S receiver. It is the receive-side counterpart of the existing i2s transmitter.
- It samples externally driven rx_sclk, rx_lrclk and rx_sd in the clk_i2s domain and deserialises standard Philips I2S frames: MSB first, one-bit delay after the lrclk edge, lrclk low = left.
- It presents one stereo sample pair per frame with a single-cycle valid strobe. Typical uses are codec ADC capture and loopback checking against the transmitter.

---
 rtl/i2s_rx.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2s_rx.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_rx
//  Description : Slave-mode Philips I2S receiver. Synchronises externally
//                driven bit clock, word select and data into clk_i2s,
//                deserialises MSB-first slots (one-bit delay after the word
//                select edge, lrclk low = left) and presents one stereo pair
//                per frame with a single-cycle valid strobe. Slots shorter
//                than DATA_WIDTH bits raise a single-cycle error strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_rx #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i2s,
    input  logic                  reset_n,
    input  logic                  rx_sclk,
    input  logic                  rx_lrclk,
    input  logic                  rx_sd,
    output logic [DATA_WIDTH-1:0] rx_data_l,
    output logic [DATA_WIDTH-1:0] rx_data_r,
    output logic                  rx_valid,
    output logic                  rx_err
);

    // Fewer than two synchroniser flops would not give metastability margin.
    localparam int c_stages = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    // Bit counter must hold DATA_WIDTH+1 (the saturation value).
    localparam int                 c_cnt_w   = $clog2(DATA_WIDTH + 2);
    localparam logic [c_cnt_w-1:0] c_dw      = c_cnt_w'(DATA_WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DATA_WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser chains
    // ------------------------------------------------------------------
    logic [c_stages-1:0] r_sclk_sync;
    logic [c_stages-1:0] r_lrclk_sync;
    logic [c_stages-1:0] r_sd_sync;

    logic w_sclk_s;
    logic w_lrclk_s;
    logic w_sd_s;

    // Shift each asynchronous input through its own flop chain.
    always_ff @(posedge clk_i2s or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_sync  <= '0;
            r_lrclk_sync <= '0;
            r_sd_sync    <= '0;
        end else begin
            r_sclk_sync  <= {r_sclk_sync[c_stages-2:0],  rx_sclk};
            r_lrclk_sync <= {r_lrclk_sync[c_stages-2:0], rx_lrclk};
            r_sd_sync    <= {r_sd_sync[c_stages-2:0],    rx_sd};
        end
    end

    assign w_sclk_s  = r_sclk_sync[c_stages-1];
    assign w_lrclk_s = r_lrclk_sync[c_stages-1];
    assign w_sd_s    = r_sd_sync[c_stages-1];

    // ------------------------------------------------------------------
    // Rising-edge detection; data and word select are sampled alongside
    // so all three stay aligned with the registered edge strobe.
    // ------------------------------------------------------------------
    logic r_sclk_prev;
    logic r_rise;
    logic r_sd_q;
    logic r_ws_q;

    // Register the bit-clock rising edge together with the bit and word select.
    always_ff @(posedge clk_i2s or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_prev <= 1'b0;
            r_rise      <= 1'b0;
            r_sd_q      <= 1'b0;
            r_ws_q      <= 1'b0;
        end else begin
            r_sclk_prev <= w_sclk_s;
            r_rise      <= w_sclk_s & ~r_sclk_prev;
            r_sd_q      <= w_sd_s;
            r_ws_q      <= w_lrclk_s;
        end
    end

    // ------------------------------------------------------------------
    // Capture stage: word-select history, bit counter and shift register
    // ------------------------------------------------------------------
    logic                  r_ws_d;      // word select seen at the previous edge
    logic                  r_ws_dd;     // word select seen two edges ago
    logic [c_cnt_w-1:0]    r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;

    // One-cycle event summary handed to the frame state machine.
    logic                  r_ev;
    logic                  r_ev_start;
    logic                  r_ev_chan;
    logic                  r_ev_short;

    logic                  w_slot_start;
    logic [c_cnt_w-1:0]    w_cnt_next;

    // Slot start and next bit position for the current edge.
    always_comb begin
        w_slot_start = (r_ws_d != r_ws_dd);
        if (w_slot_start) begin
            w_cnt_next = c_cnt_one;
        end else if (r_bit_cnt == c_cnt_max) begin
            w_cnt_next = r_bit_cnt;
        end else begin
            w_cnt_next = r_bit_cnt + c_cnt_one;
        end
    end

    // On each bit-clock edge, update the word-select history and shift in the bit.
    always_ff @(posedge clk_i2s or negedge reset_n) begin
        if (!reset_n) begin
            r_ws_d     <= 1'b0;
            r_ws_dd    <= 1'b0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_ev       <= 1'b0;
            r_ev_start <= 1'b0;
            r_ev_chan  <= 1'b0;
            r_ev_short <= 1'b0;
        end else begin
            r_ev <= r_rise;
            if (r_rise) begin
                r_ws_d     <= r_ws_q;
                r_ws_dd    <= r_ws_d;
                r_bit_cnt  <= w_cnt_next;
                // Bits past DATA_WIDTH in long slots are dropped.
                if (w_cnt_next <= c_dw) begin
                    r_shift <= {r_shift[DATA_WIDTH-2:0], r_sd_q};
                end
                r_ev_start <= w_slot_start;
                r_ev_chan  <= r_ws_d;
                // The slot that just ended was short if it never reached DATA_WIDTH.
                r_ev_short <= (r_bit_cnt < c_dw);
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame state machine and output registers
    // ------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_next;
    logic                  r_left_ok;
    logic                  w_left_ok_next;
    logic [DATA_WIDTH-1:0] r_left_hold;
    logic [DATA_WIDTH-1:0] w_left_hold_next;
    logic [DATA_WIDTH-1:0] w_data_l_next;
    logic [DATA_WIDTH-1:0] w_data_r_next;
    logic                  w_valid_next;
    logic                  w_err_next;

    // State, held left sample and all outputs.
    always_ff @(posedge clk_i2s or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= SEARCH;
            r_left_ok   <= 1'b0;
            r_left_hold <= '0;
            rx_data_l   <= '0;
            rx_data_r   <= '0;
            rx_valid    <= 1'b0;
            rx_err      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_left_ok   <= w_left_ok_next;
            r_left_hold <= w_left_hold_next;
            rx_data_l   <= w_data_l_next;
            rx_data_r   <= w_data_r_next;
            rx_valid    <= w_valid_next;
            rx_err      <= w_err_next;
        end
    end

    // Slot-start handling first, then completion of the (possibly new) slot.
    always_comb begin
        w_state_next     = r_state;
        w_left_ok_next   = r_left_ok;
        w_left_hold_next = r_left_hold;
        w_data_l_next    = rx_data_l;
        w_data_r_next    = rx_data_r;
        w_valid_next     = 1'b0;
        w_err_next       = 1'b0;

        if (r_ev) begin
            if (r_ev_start) begin
                case (r_state)
                    SEARCH: begin
                        // Only a fresh left slot can begin a frame.
                        if (!r_ev_chan) begin
                            w_state_next = LEFT;
                        end
                    end
                    default: begin
                        if (r_ev_short) begin
                            w_err_next     = 1'b1;
                            w_left_ok_next = 1'b0;
                            w_state_next   = r_ev_chan ? SEARCH : LEFT;
                        end else begin
                            w_state_next   = r_ev_chan ? RIGHT : LEFT;
                        end
                    end
                endcase
            end

            if (r_bit_cnt == c_dw) begin
                if (w_state_next == LEFT) begin
                    w_left_hold_next = r_shift;
                    w_left_ok_next   = 1'b1;
                end else if ((w_state_next == RIGHT) && w_left_ok_next) begin
                    w_data_l_next  = r_left_hold;
                    w_data_r_next  = r_shift;
                    w_valid_next   = 1'b1;
                    w_left_ok_next = 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire
